config_frame_loader: RTL and testbench

- Upstream feeder of the fabric configuration latch array.
- Accepts a 32-bit configuration word stream over a valid/ready handshake and locks onto a sync word.
- Assembles one frame per header (column, frame index) and drives FrameData plus a one-hot FrameStrobe pulse that acts as the latch enable E of the addressed column's frame latches.
- Guarantees FrameData is stable one cycle before, during, and one cycle after every strobe.

---
 rtl/fabric_cfg_pkg.sv | 30 +++
 rtl/cfg_strobe_decoder.sv | 31 +++
 rtl/config_frame_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_config_frame_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fabric_cfg_pkg
// Shared definitions for the configuration frame loader: loader FSM states,
// stream control words and the bit positions of the header fields.
// No ports (package).
// -----------------------------------------------------------------------------
package fabric_cfg_pkg;

   // Loader FSM states. CHK is only entered when the checksum word is enabled.
   typedef enum logic [2:0] {
      SEARCH,
      HDR,
      DATA,
      CHK,
      PRE,
      STROBE,
      HOLD
   } state_e;

   // Stream control words.
   localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

   // Header word layout: [23:16] column, [4:0] frame index.
   localparam int COL_LSB = 16;
   localparam int COL_W   = 8;
   localparam int FRM_LSB = 0;
   localparam int FRM_W   = 5;

endpackage : fabric_cfg_pkg

// File: rtl/cfg_strobe_decoder.sv
// -----------------------------------------------------------------------------
// cfg_strobe_decoder
// Combinational decode of a (column, frame) address into the one-hot frame
// latch enable vector. Bit index is col*FRAMES_PER_COL + frm. All zeros when
// en is low or the address is outside the array.
// Ports:
//   en      in   decode enable
//   col     in   column address  [COL_W-1:0]
//   frm     in   frame address   [FRM_W-1:0]
//   onehot  out  one-hot enable  [NUM_COLS*FRAMES_PER_COL-1:0]
// -----------------------------------------------------------------------------
module cfg_strobe_decoder
   import fabric_cfg_pkg::*;
#(
   parameter int NUM_COLS       = 4,
   parameter int FRAMES_PER_COL = 20
) (
   input  logic                               en,
   input  logic [COL_W-1:0]                   col,
   input  logic [FRM_W-1:0]                   frm,
   output logic [NUM_COLS*FRAMES_PER_COL-1:0] onehot
);

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      for (genvar f = 0; f < FRAMES_PER_COL; f++) begin : g_frm
         assign onehot[c*FRAMES_PER_COL + f] =
            en && (col == COL_W'(c)) && (frm == FRM_W'(f));
      end
   end

endmodule : cfg_strobe_decoder

// File: rtl/config_frame_loader.sv
// -----------------------------------------------------------------------------
// config_frame_loader
// Upstream feeder of the fabric configuration latch array. Locks onto a SYNC
// word in a 32-bit valid/ready stream, assembles one frame (NUM_ROWS words)
// per header and pulses the addressed frame's latch enable for STROBE_CYCLES
// cycles while FrameData is held stable around the pulse.
// Optional checksum word: define CONFIG_FRAME_LOADER_CHECKSUM_EN.
// Ports:
//   CLK             in   fabric clock
//   resetn          in   synchronous active-low reset
//   cfg_word        in   stream word [31:0]
//   cfg_valid       in   cfg_word valid
//   cfg_ready       out  loader accepts a word (transfer on valid & ready)
//   FrameData       out  frame data, row r = bits [32r+31:32r]
//   FrameStrobe     out  one-hot latch enable, bit col*FRAMES_PER_COL+frame
//   cfg_active      out  high while synced (state other than SEARCH)
//   cfg_err         out  sticky address/checksum error
//   frames_written  out  saturating count of strobed frames
// -----------------------------------------------------------------------------
module config_frame_loader
   import fabric_cfg_pkg::*;
#(
   parameter int NUM_ROWS       = 4,
   parameter int NUM_COLS       = 4,
   parameter int FRAMES_PER_COL = 20,
   parameter int STROBE_CYCLES  = 2
) (
   input  logic                               CLK,
   input  logic                               resetn,
   input  logic [31:0]                        cfg_word,
   input  logic                               cfg_valid,
   output logic                               cfg_ready,
   output logic [NUM_ROWS*32-1:0]             FrameData,
   output logic [NUM_COLS*FRAMES_PER_COL-1:0] FrameStrobe,
   output logic                               cfg_active,
   output logic                               cfg_err,
   output logic [15:0]                        frames_written
);

   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int STB_W   = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
   localparam int NUM_STB = NUM_COLS * FRAMES_PER_COL;

   state_e                    state_q, state_d;
   logic                      accepting;
   logic                      accept;
   logic                      is_sync;
   logic                      is_desync;
   logic                      hdr_bad;
   logic                      last_row;
   logic                      stb_last;
   logic [COL_W-1:0]          hdr_col_q;
   logic [FRM_W-1:0]          hdr_frm_q;
   logic                      discard_q;
   logic [ROW_W-1:0]          row_cnt_q;
   logic [STB_W-1:0]          stb_cnt_q;
   logic [NUM_ROWS-1:0][31:0] shadow_q;
   logic [NUM_STB-1:0]        strobe_d;
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
   logic [31:0]               csum_q;
`else
   logic [NUM_ROWS-1:0][31:0] shadow_full;
`endif

   // ---------------------------------------------------------------------
   // Handshake and word classification
   // ---------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default at the top,
   // so no path through the block leaves it unassigned and infers a latch.
   always_comb begin
      accepting = 1'b0;
      case (state_q)
         SEARCH, HDR, DATA, CHK: accepting = 1'b1;
         default:                accepting = 1'b0;
      endcase
   end

   // Ready is held low throughout the reset cycle itself.
   assign cfg_ready  = resetn && accepting;
   assign accept     = cfg_valid && cfg_ready;
   assign cfg_active = (state_q != SEARCH);

   assign is_sync   = (cfg_word == SYNC_WORD);
   assign is_desync = (cfg_word == DESYNC_WORD);
   assign hdr_bad   =
      ({{(32-COL_W){1'b0}}, cfg_word[COL_LSB +: COL_W]} >= 32'(NUM_COLS)) ||
      ({{(32-FRM_W){1'b0}}, cfg_word[FRM_LSB +: FRM_W]} >= 32'(FRAMES_PER_COL));
   assign last_row  = (row_cnt_q == ROW_W'(NUM_ROWS - 1));
   assign stb_last  = (stb_cnt_q == STB_W'(STROBE_CYCLES - 1));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples values from before the edge, independent of block order.
   always_ff @(posedge CLK) begin
      if (!resetn) state_q <= SEARCH;
      else         state_q <= state_d;
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SEARCH: if (accept && is_sync) state_d = HDR;
         HDR: begin
            if (accept) begin
               if (is_desync)    state_d = SEARCH;
               else if (is_sync) state_d = HDR;
               else              state_d = DATA;
            end
         end
         DATA: begin
            if (accept && last_row) begin
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = discard_q ? HDR : PRE;
`endif
            end
         end
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
         CHK: begin
            if (accept) state_d = (discard_q || (cfg_word != csum_q)) ? HDR : PRE;
         end
`endif
         PRE:    state_d = STROBE;
         STROBE: if (stb_last) state_d = HOLD;
         HOLD:   state_d = HDR;
         default: state_d = SEARCH;
      endcase
   end

   // ---------------------------------------------------------------------
   // Strobe decode. The registered strobe trails STROBE by one cycle, so
   // FrameData (loaded on entry to PRE) is stable a full cycle before the
   // rise, and the last strobe cycle overlaps HOLD so data is also stable
   // a full cycle after the fall.
   // ---------------------------------------------------------------------
   cfg_strobe_decoder #(
      .NUM_COLS       (NUM_COLS),
      .FRAMES_PER_COL (FRAMES_PER_COL)
   ) u_strobe_decoder (
      .en     (state_q == STROBE),
      .col    (hdr_col_q),
      .frm    (hdr_frm_q),
      .onehot (strobe_d)
   );

   // ---------------------------------------------------------------------
   // Shadow row registers
   // ---------------------------------------------------------------------
   // NOTE: the shadow rows carry no reset; every row is rewritten in DATA
   // before the shadow can ever be copied to FrameData.
   always_ff @(posedge CLK) begin
      if ((state_q == DATA) && accept) shadow_q[row_cnt_q] <= cfg_word;
   end

`ifndef CONFIG_FRAME_LOADER_CHECKSUM_EN
   // Shadow including the word being accepted now, so the last row can be
   // published on the same edge that accepts it.
   always_comb begin
      shadow_full            = shadow_q;
      shadow_full[row_cnt_q] = cfg_word;
   end
`endif

   // ---------------------------------------------------------------------
   // Datapath and status registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!resetn) begin
         FrameData      <= '0;
         FrameStrobe    <= '0;
         cfg_err        <= 1'b0;
         frames_written <= '0;
         hdr_col_q      <= '0;
         hdr_frm_q      <= '0;
         discard_q      <= 1'b0;
         row_cnt_q      <= '0;
         stb_cnt_q      <= '0;
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
         csum_q         <= '0;
`endif
      end else begin
         FrameStrobe <= strobe_d;
         unique case (state_q)
            HDR: begin
               if (accept && !is_sync && !is_desync) begin
                  hdr_col_q <= cfg_word[COL_LSB +: COL_W];
                  hdr_frm_q <= cfg_word[FRM_LSB +: FRM_W];
                  discard_q <= hdr_bad;
                  row_cnt_q <= '0;
                  if (hdr_bad) cfg_err <= 1'b1;
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
                  csum_q    <= cfg_word;
`endif
               end
            end
            DATA: begin
               if (accept) begin
                  row_cnt_q <= last_row ? '0 : row_cnt_q + 1'b1;
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
                  csum_q    <= csum_q ^ cfg_word;
`else
                  if (last_row && !discard_q) FrameData <= shadow_full;
`endif
               end
            end
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  if (cfg_word != csum_q) cfg_err   <= 1'b1;
                  else if (!discard_q)    FrameData <= shadow_q;
               end
            end
`endif
            STROBE: begin
               stb_cnt_q <= stb_last ? '0 : stb_cnt_q + 1'b1;
               // Count once per frame, on the edge the strobe rises.
               if ((stb_cnt_q == '0) && (frames_written != 16'hFFFF))
                  frames_written <= frames_written + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule : config_frame_loader

// File: tb/tb_config_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_config_frame_loader
// Directed bench for config_frame_loader with default parameters. Expected
// strobes (bit, rise cycle, frame data) are queued as frames are sent and
// consumed by a monitor when the DUT raises FrameStrobe.
// Define CONFIG_FRAME_LOADER_CHECKSUM_EN for both bench and RTL to exercise
// the checksum word.
// -----------------------------------------------------------------------------
module tb_config_frame_loader;

   localparam int NUM_ROWS       = 4;
   localparam int NUM_COLS       = 4;
   localparam int FRAMES_PER_COL = 20;
   localparam int STROBE_CYCLES  = 2;
   localparam int NUM_STB        = NUM_COLS * FRAMES_PER_COL;
   localparam int BUDGET         = 60;

   localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

   logic                      CLK = 1'b0;
   logic                      resetn;
   logic [31:0]               cfg_word;
   logic                      cfg_valid;
   logic                      cfg_ready;
   logic [NUM_ROWS*32-1:0]    FrameData;
   logic [NUM_STB-1:0]        FrameStrobe;
   logic                      cfg_active;
   logic                      cfg_err;
   logic [15:0]               frames_written;

   typedef struct {
      int           idx;
      int           cyc;
      logic [127:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   last_acc = 0;

   config_frame_loader #(
      .NUM_ROWS       (NUM_ROWS),
      .NUM_COLS       (NUM_COLS),
      .FRAMES_PER_COL (FRAMES_PER_COL),
      .STROBE_CYCLES  (STROBE_CYCLES)
   ) dut (
      .CLK            (CLK),
      .resetn         (resetn),
      .cfg_word       (cfg_word),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .FrameData      (FrameData),
      .FrameStrobe    (FrameStrobe),
      .cfg_active     (cfg_active),
      .cfg_err        (cfg_err),
      .frames_written (frames_written)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [31:0] w, input int gap);
      int n = 0;
      cfg_valid = 1'b0;
      repeat (gap) @(negedge CLK);
      cfg_word  = w;
      cfg_valid = 1'b1;
      while (!cfg_ready && n < BUDGET) begin
         @(negedge CLK);
         n++;
      end
      check("send_ready_bound", 128'(n < BUDGET), 128'(1));
      @(negedge CLK);
      last_acc  = cyc;
      cfg_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] hdr, input logic [127:0] data,
                             input int max_gap, input bit push, input int idx);
      exp_t e;
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
      logic [31:0] csum;
      csum = hdr;
`endif
      send_word(hdr, int'($urandom_range(max_gap, 0)));
      for (int r = 0; r < NUM_ROWS; r++) begin
         send_word(data[32*r +: 32], int'($urandom_range(max_gap, 0)));
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
         csum = csum ^ data[32*r +: 32];
`endif
      end
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
      send_word(csum, int'($urandom_range(max_gap, 0)));
`endif
      if (push) begin
         e.idx  = idx;
         e.cyc  = last_acc + 2;
         e.data = data;
         exp_q.push_back(e);
      end
   endtask

`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
   task automatic send_bad_csum_frame(input logic [31:0] hdr, input logic [127:0] data);
      logic [31:0] csum;
      csum = hdr;
      send_word(hdr, 0);
      for (int r = 0; r < NUM_ROWS; r++) begin
         send_word(data[32*r +: 32], 0);
         csum = csum ^ data[32*r +: 32];
      end
      send_word(csum ^ 32'h1, 0);
   endtask
`endif

   task automatic wait_ready(output int at);
      int n = 0;
      while (!cfg_ready && n < BUDGET) begin
         @(negedge CLK);
         n++;
      end
      check("wait_ready_bound", 128'(n < BUDGET), 128'(1));
      at = cyc;
   endtask

   // ---------------------------------------------------------------------
   // Strobe monitor: pops the scoreboard on every rising strobe and checks
   // bit, timing, pulse length, one-hotness and FrameData stability.
   // ---------------------------------------------------------------------
   logic [127:0] prev_data = '0;
   logic [127:0] run_data  = '0;
   int           run_len   = 0;
   bit           in_run    = 1'b0;

   always @(negedge CLK) begin
      exp_t e;
      if (resetn !== 1'b1) begin
         in_run  = 1'b0;
         run_len = 0;
      end else if (FrameStrobe != '0) begin
         check("strobe_onehot", 128'($onehot(FrameStrobe)), 128'(1));
         check("ready_low_during_strobe", 128'(cfg_ready), 128'(0));
         if (!in_run) begin
            in_run   = 1'b1;
            run_len  = 1;
            run_data = FrameData;
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 128'(FrameStrobe), 128'(0));
            end else begin
               e = exp_q.pop_front();
               check("strobe_bit", 128'(FrameStrobe), 128'(1) << e.idx);
               check("strobe_rise_cycle", 128'(cyc), 128'(e.cyc));
               check("data_at_strobe", FrameData, e.data);
               check("data_cycle_before", prev_data, e.data);
            end
         end else begin
            run_len++;
            check("data_during_strobe", FrameData, run_data);
         end
      end else if (in_run) begin
         in_run = 1'b0;
         check("strobe_length", 128'(run_len), 128'(STROBE_CYCLES));
         check("data_cycle_after", FrameData, run_data);
      end
      prev_data = FrameData;
   end

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      int           at;
      int           prev_acc;
      int           n;
      logic [127:0] d_a;
      logic [127:0] d_b;

      d_a = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      // SYNC and DESYNC values as data rows must be taken as plain data.
      d_b = {32'h0F0F_0F0F, 32'hA5A5_A5A5, DESYNC, SYNC};

      resetn    = 1'b0;
      cfg_valid = 1'b0;
      cfg_word  = '0;

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_ready", 128'(cfg_ready), 128'(0));
      check("rst_data", FrameData, '0);
      check("rst_strobe", 128'(FrameStrobe), '0);
      check("rst_err", 128'(cfg_err), '0);
      check("rst_frames", 128'(frames_written), '0);
      check("rst_active", 128'(cfg_active), '0);
      resetn = 1'b1;
      @(negedge CLK);
      check("ready_after_rst", 128'(cfg_ready), 128'(1));

      // Header and data before SYNC are discarded
      send_frame(32'h0001_0003, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 0, 1'b0, 0);
      check("nosync_active", 128'(cfg_active), 128'(0));
      check("nosync_frames", 128'(frames_written), 128'(0));

      // Basic frame: column 2, frame 5 -> bit 45
      send_word(SYNC, 0);
      check("sync_active", 128'(cfg_active), 128'(1));
      send_frame(32'h0002_0005, d_a, 0, 1'b1, 45);
      wait_ready(at);
      check("ready_return_cycle", 128'(at), 128'(last_acc + 2 + STROBE_CYCLES));
      check("frame1_data", FrameData, d_a);
      check("frame1_count", 128'(frames_written), 128'(1));

      // Frame index 20 out of range
      send_frame(32'h0000_0014, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 0, 1'b0, 0);
      check("frm_oob_err", 128'(cfg_err), 128'(1));
      check("frm_oob_ready", 128'(cfg_ready), 128'(1));
      // Column 4 out of range
      send_frame(32'h0004_0000, {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001},
                 0, 1'b0, 0);
      check("col_oob_data_kept", FrameData, d_a);
      check("col_oob_frames", 128'(frames_written), 128'(1));
      // Next valid frame, last column/frame: bit 79
      send_frame(32'h0003_0013, d_b, 0, 1'b1, 79);
      wait_ready(at);
      check("frame_after_oob_count", 128'(frames_written), 128'(2));

      // Random valid gaps; next word offered during PRE/STROBE/HOLD
      send_frame(32'h0001_000A, d_b, 3, 1'b1, 30);
      prev_acc = last_acc;
      send_word(SYNC, 0);
      check("accept_after_hold", 128'(last_acc), 128'(prev_acc + 3 + STROBE_CYCLES));
      check("gap_frame_data", FrameData, d_b);
      check("gap_frame_count", 128'(frames_written), 128'(3));

      // Reset during STROBE
      send_frame(32'h0000_0000, d_a, 0, 1'b1, 0);
      n = 0;
      while (FrameStrobe == '0 && n < BUDGET) begin
         @(negedge CLK);
         n++;
      end
      check("strobe_seen_bound", 128'(n < BUDGET), 128'(1));
      #1 resetn = 1'b0;
      @(negedge CLK);
      check("midrst_strobe", 128'(FrameStrobe), '0);
      check("midrst_data", FrameData, '0);
      check("midrst_err", 128'(cfg_err), '0);
      check("midrst_frames", 128'(frames_written), '0);
      check("midrst_active", 128'(cfg_active), '0);
      check("midrst_ready", 128'(cfg_ready), '0);
      #1 resetn = 1'b1;
      @(negedge CLK);
      // SYNC required again
      send_frame(32'h0000_0001, d_b, 0, 1'b0, 0);
      check("resync_needed_active", 128'(cfg_active), '0);
      check("resync_needed_frames", 128'(frames_written), '0);
      send_word(SYNC, 0);
      send_frame(32'h0002_0013, d_b, 1, 1'b1, 59);
      wait_ready(at);
      check("post_rst_frame_count", 128'(frames_written), 128'(1));
      check("post_rst_err", 128'(cfg_err), '0);

`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
      // Checksum with bit 0 flipped: error, no strobe, data unchanged
      send_bad_csum_frame(32'h0001_0001, d_a);
      check("bad_csum_err", 128'(cfg_err), 128'(1));
      check("bad_csum_ready", 128'(cfg_ready), 128'(1));
      repeat (6) @(negedge CLK);
      check("bad_csum_frames", 128'(frames_written), 128'(1));
      check("bad_csum_data", FrameData, d_b);
`endif

      // DESYNC returns to SEARCH
      send_word(DESYNC, 0);
      check("desync_active", 128'(cfg_active), '0);

      repeat (8) @(negedge CLK);
      check("scoreboard_empty", 128'(exp_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_config_frame_loader
